serial_loader: RTL

//   Serial-to-parallel front end that feeds the WIDTH-bit load/clear register.

---
 rtl/serial_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_loader.sv
// Serial-to-parallel front end for a WIDTH-bit load/clear register: gathers strobed
// bits into a word, pulses load when the word completes, pulses clear on abort.
module serial_loader #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             abort,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic             clear,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     count_r;
    logic [WIDTH-1:0]  buf_r;
    logic [WIDTH-1:0]  d_r;
    logic              load_r;
    logic              clear_r;
    logic              busy_r;
    logic [WIDTH-1:0]  shifted_s;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[WIDTH-2:0], b};
        end else begin
            res = {b, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Next buffer contents if the offered bit is accepted this cycle.
    always_comb begin
        shifted_s = shift_in(buf_r, serial_in);
    end

    // Frame FSM; abort outranks everything and d only changes on a completed word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            count_r <= CNT_ZERO;
            buf_r   <= {WIDTH{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            load_r  <= 1'b0;
            clear_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            load_r  <= 1'b0;
            clear_r <= 1'b0;
            if (abort) begin
                state_r <= IDLE;
                count_r <= CNT_ZERO;
                buf_r   <= {WIDTH{1'b0}};
                clear_r <= 1'b1;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            state_r <= SHIFT;
                            count_r <= CNT_ZERO;
                            buf_r   <= {WIDTH{1'b0}};
                            busy_r  <= 1'b1;
                        end else begin
                            busy_r  <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (bit_valid) begin
                            buf_r   <= shifted_s;
                            count_r <= count_r + CNT_ONE;
                            if (count_r == CNT_LAST) begin
                                d_r     <= shifted_s;
                                load_r  <= 1'b1;
                                state_r <= LOAD;
                            end else begin
                                state_r <= SHIFT;
                            end
                        end else begin
                            state_r <= SHIFT;
                        end
                        busy_r <= 1'b1;
                    end
                    LOAD: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        count_r <= CNT_ZERO;
                        buf_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign d     = d_r;
    assign load  = load_r;
    assign clear = clear_r;
    assign busy  = busy_r;

endmodule
